uart_tx_line_buf: RTL and testbench

Line buffer between the stream-cipher stage and the UART transmitter. It captures the cipher's output bytes (ciphertext hex digits or printable plaintext), one per `wr_rdy` pulse, into an on-chip FIFO. On a print request it drains the captured line to the transmitter over a valid/ready handshake, then appends CR LF. Bytes arriving during a drain are held for the next line.

---
 rtl/uart_pkg.sv | 14 +
 rtl/sync_fifo.sv | 70 +++++++
 rtl/uart_tx_line_buf.sv | 107 ++++++++++
 tb/tb_uart_tx_line_buf.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants and state type for the UART transmit path.
package uart_pkg;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    typedef enum logic [1:0] {
        TXLB_IDLE,
        TXLB_DRAIN,
        TXLB_CR,
        TXLB_LF
    } txlb_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a registered head: dout is the oldest entry one cycle after any push/pop.
// Push while full and pop while empty are ignored; full/empty/count are registered.
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int DW    = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [DW-1:0]          din,
    output logic [DW-1:0]          dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [DW-1:0] dout_q, dout_d;
    logic          full_q, empty_q;
    logic          push_ok, pop_ok;

    always_comb begin
        push_ok  = push & ~full_q;
        pop_ok   = pop & ~empty_q;
        rd_ptr_d = pop_ok ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + CW'(1);
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - CW'(1);
        end
        // Writing into the slot that becomes the head: forward din so the head is never stale.
        dout_d = (push_ok && (wr_ptr_q == rd_ptr_d)) ? din : mem[rd_ptr_d];
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            dout_q   <= '0;
        end else begin
            wr_ptr_q <= push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= (count_d == CW'(DEPTH));
            empty_q  <= (count_d == '0);
            dout_q   <= dout_d;
        end
    end

    assign dout  = dout_q;
    assign count = count_q;
    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: rtl/uart_tx_line_buf.sv
// Buffers cipher bytes and on print drains a snapshot of them to the UART, then CR LF.
// First byte one cycle after print, one byte per cycle when tx_ready is high; stalls hold tx_data.
module uart_tx_line_buf
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int DW    = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DW-1:0]          wr_data,
    input  logic                   wr_rdy,
    input  logic                   print,
    output logic [DW-1:0]          tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full,
    output logic                   overflow,
    output logic                   busy
);
    localparam int CW = $clog2(DEPTH) + 1;

    txlb_state_t   state_q, state_d;
    logic [CW-1:0] remain_q, remain_d;
    logic          overflow_q, overflow_d;
    logic [DW-1:0] head;
    logic          fifo_pop;

    sync_fifo #(.DEPTH(DEPTH), .DW(DW)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_rdy),
        .pop   (fifo_pop),
        .din   (wr_data),
        .dout  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= TXLB_IDLE;
            remain_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            remain_q   <= remain_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        remain_d   = remain_q;
        overflow_d = overflow_q;
        tx_valid   = 1'b0;
        tx_data    = '0;
        fifo_pop   = 1'b0;
        case (state_q)
            TXLB_IDLE: begin
                // Snapshot keeps bytes arriving mid-line out of this line.
                if (print) begin
                    remain_d = count;
                    state_d  = (count != '0) ? TXLB_DRAIN : TXLB_CR;
                end
            end
            TXLB_DRAIN: begin
                tx_valid = 1'b1;
                tx_data  = head;
                if (tx_ready) begin
                    fifo_pop = 1'b1;
                    remain_d = remain_q - CW'(1);
                    if (remain_q == CW'(1)) begin
                        state_d = TXLB_CR;
                    end
                end
            end
            TXLB_CR: begin
                tx_valid = 1'b1;
                tx_data  = DW'(ASCII_CR);
                if (tx_ready) begin
                    state_d = TXLB_LF;
                end
            end
            TXLB_LF: begin
                tx_valid = 1'b1;
                tx_data  = DW'(ASCII_LF);
                if (tx_ready) begin
                    state_d    = TXLB_IDLE;
                    overflow_d = 1'b0;
                end
            end
            default: state_d = TXLB_IDLE;
        endcase
        // A drop in the same cycle as the LF handshake must still be reported.
        if (wr_rdy && full) begin
            overflow_d = 1'b1;
        end
    end

    assign busy     = (state_q != TXLB_IDLE);
    assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_line_buf.sv
// Bench for uart_tx_line_buf: directed line scenarios plus random traffic against a queue-based model.
module tb_uart_tx_line_buf;
    import uart_pkg::*;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] wr_data = 8'h00;
    logic       wr_rdy = 1'b0;
    logic       print = 1'b0;
    logic       tx_ready = 1'b0;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic [4:0] count;
    logic       empty, full, overflow, busy;

    uart_tx_line_buf #(.DEPTH(DEPTH), .DW(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_data  (wr_data),
        .wr_rdy   (wr_rdy),
        .print    (print),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .count    (count),
        .empty    (empty),
        .full     (full),
        .overflow (overflow),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: stored bytes, and the bytes still owed to the UART for the line in progress.
    // Owed entries carry bit 8 = 1 when they come out of the buffer (and so free a slot).
    logic [7:0] m_buf[$];
    logic [8:0] m_owed[$];
    logic       m_ovf = 1'b0;

    logic [7:0] seen[$];
    logic [7:0] want[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        chk("tx_valid", 32'(tx_valid), 32'(m_owed.size() != 0));
        chk("busy", 32'(busy), 32'(m_owed.size() != 0));
        if (m_owed.size() != 0) chk("tx_data", 32'(tx_data), 32'(m_owed[0][7:0]));
        chk("count", 32'(count), 32'(m_buf.size()));
        chk("empty", 32'(empty), 32'(m_buf.size() == 0));
        chk("full", 32'(full), 32'(m_buf.size() == DEPTH));
        chk("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    task automatic step(input logic w, input logic [7:0] d, input logic p, input logic r, input logic rs);
        bit was_idle, was_full;
        logic [8:0] it;
        rst = rs; wr_rdy = w; wr_data = d; print = p; tx_ready = r;
        if (tx_valid && r && !rs) seen.push_back(tx_data);
        if (rs) begin
            m_buf.delete(); m_owed.delete(); m_ovf = 1'b0;
        end else begin
            was_idle = (m_owed.size() == 0);
            was_full = (m_buf.size() == DEPTH);
            if (!was_idle && r) begin
                it = m_owed.pop_front();
                if (it[8]) void'(m_buf.pop_front());
                if (it == {1'b0, ASCII_LF}) m_ovf = 1'b0;
            end
            if (was_idle && p) begin
                foreach (m_buf[i]) m_owed.push_back({1'b1, m_buf[i]});
                m_owed.push_back({1'b0, ASCII_CR});
                m_owed.push_back({1'b0, ASCII_LF});
            end
            if (w) begin
                if (was_full) m_ovf = 1'b1;
                else m_buf.push_back(d);
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic cmp_seen(input string tag);
        chk({tag, "_len"}, 32'(seen.size()), 32'(want.size()));
        for (int i = 0; i < want.size(); i++) begin
            if (i < seen.size()) chk(tag, 32'(seen[i]), 32'(want[i]));
        end
        seen.delete();
    endtask

    initial begin
        logic [7:0] b;

        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("reset_tx_data", 32'(tx_data), 32'h00);
        chk("reset_tx_valid", 32'(tx_valid), 32'h0);
        chk("reset_empty", 32'(empty), 32'h1);

        // Basic line "4A3F"
        want = '{8'h34, 8'h41, 8'h33, 8'h46};
        foreach (want[i]) step(1'b1, want[i], 1'b0, 1'b1, 1'b0);
        chk("basic_count", 32'(count), 32'd4);
        seen.delete();
        step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        idle_n(6);
        want = '{8'h34, 8'h41, 8'h33, 8'h46, 8'h0D, 8'h0A};
        cmp_seen("basic_line");
        chk("basic_busy", 32'(busy), 32'h0);
        chk("basic_empty", 32'(empty), 32'h1);

        // Empty print
        step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        idle_n(3);
        want = '{8'h0D, 8'h0A};
        cmp_seen("empty_line");

        // Backpressure, ready pattern 1 0 0 1
        want = '{8'hC3, 8'h07, 8'h9E};
        foreach (want[i]) step(1'b1, want[i], 1'b0, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 16; k++) step(1'b0, 8'h00, 1'b0, (k % 4 == 0) || (k % 4 == 3), 1'b0);
        want = '{8'hC3, 8'h07, 8'h9E, 8'h0D, 8'h0A};
        cmp_seen("backpressure_line");

        // Overflow: 18 writes into 16 slots
        for (int i = 0; i < 18; i++) step(1'b1, 8'(8'h41 + i), 1'b0, 1'b1, 1'b0);
        chk("ovf_full", 32'(full), 32'h1);
        chk("ovf_flag", 32'(overflow), 32'h1);
        step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        idle_n(19);
        want.delete();
        for (int i = 0; i < 16; i++) want.push_back(8'(8'h41 + i));
        want.push_back(8'h0D); want.push_back(8'h0A);
        cmp_seen("ovf_line");
        chk("ovf_cleared", 32'(overflow), 32'h0);

        // Write during drain
        step(1'b1, 8'h11, 1'b0, 1'b1, 1'b0);
        step(1'b1, 8'h22, 1'b0, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        step(1'b1, 8'h5A, 1'b0, 1'b1, 1'b0);
        idle_n(4);
        want = '{8'h11, 8'h22, 8'h0D, 8'h0A};
        cmp_seen("wdd_line1");
        chk("wdd_count", 32'(count), 32'd1);
        step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        idle_n(4);
        want = '{8'h5A, 8'h0D, 8'h0A};
        cmp_seen("wdd_line2");

        // Reset in the middle of DRAIN
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("mid_in_drain", 32'(busy), 32'h1);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        chk("mid_rst_valid", 32'(tx_valid), 32'h0);
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        idle_n(2);

        // Random traffic against the model
        for (int k = 0; k < 3000; k++) begin
            b = 8'($urandom);
            step(($urandom % 3) == 0, b, ($urandom % 12) == 0, ($urandom % 3) != 0,
                 ($urandom % 700) == 0);
        end
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        idle_n(25);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
